light_controller: RTL and testbench



---
 rtl/light_controller_pkg.sv | 41 ++++
 rtl/light_dwell_timer.sv | 31 +++
 rtl/light_controller.sv | 89 ++++++++
 tb/tb_light_controller.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/light_controller_pkg.sv
// Shared definitions for the traffic-lamp sequencer.
//   state_t      : phase encoding (two bits, 2'b11 is unused/illegal)
//   LAMP_*       : one-hot lamp words, bit 0 = Red, bit 1 = Green, bit 2 = Yellow
//   IDX_*        : bit positions of each lamp inside a [0:2] lamp word
//   dwell_width  : counter width for the longest phase (at least one bit)
//   lamp_of      : Moore decode of a phase to its lamp word
package light_controller_pkg;

  typedef enum logic [1:0] {
    S_RED    = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2
  } state_t;

  localparam logic [0:2] LAMP_RED    = 3'b100;
  localparam logic [0:2] LAMP_GREEN  = 3'b010;
  localparam logic [0:2] LAMP_YELLOW = 3'b001;

  localparam int IDX_R = 0;
  localparam int IDX_G = 1;
  localparam int IDX_Y = 2;

  function automatic int dwell_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

  // Anything that is not a named phase shows Red, so the lamp head is never dark.
  function automatic logic [0:2] lamp_of(input state_t s);
    case (s)
      S_RED:    return LAMP_RED;
      S_GREEN:  return LAMP_GREEN;
      S_YELLOW: return LAMP_YELLOW;
      default:  return LAMP_RED;
    endcase
  endfunction

endpackage

// File: rtl/light_dwell_timer.sv
// Phase dwell timer for timed sequencers.
//   clk        : clock, counts on the rising edge
//   rst_n      : asynchronous active-low reset, count -> 0
//   clear      : synchronous restart of the count from 0
//   limit      : terminal count (phase length minus one)
//   phase_done : high while the count equals limit; the count wraps to 0 on that edge
module light_dwell_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic [W-1:0] limit,
  output logic         phase_done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || phase_done) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

  assign phase_done = (count == limit);

endmodule

// File: rtl/light_controller.sv
// Cyclic single-approach lamp sequencer: RED -> GREEN -> YELLOW -> RED.
// Each phase holds for its *_CYCLES rising edges.
//   light : one-hot lamp drive, registered; [0]=Red [1]=Green [2]=Yellow
//   clk   : clock
//   rst_n : asynchronous active-low reset (forces RED, restarts the dwell)
module light_controller
  import light_controller_pkg::*;
#(
  parameter int RED_CYCLES    = 1,
  parameter int GREEN_CYCLES  = 1,
  parameter int YELLOW_CYCLES = 1
) (
  output logic [0:2] light,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int CW = dwell_width(RED_CYCLES, GREEN_CYCLES, YELLOW_CYCLES);

  localparam logic [CW-1:0] RED_LIM    = CW'(RED_CYCLES - 1);
  localparam logic [CW-1:0] GREEN_LIM  = CW'(GREEN_CYCLES - 1);
  localparam logic [CW-1:0] YELLOW_LIM = CW'(YELLOW_CYCLES - 1);

  if (RED_CYCLES < 1 || GREEN_CYCLES < 1 || YELLOW_CYCLES < 1) begin : g_bad_param
    $error("light_controller: every *_CYCLES parameter must be >= 1");
  end

  state_t        state;
  state_t        state_next;
  logic [0:2]    light_next;
  logic [CW-1:0] limit;
  logic          illegal;
  logic          phase_done;

  // The timer restarts whenever the state is unrecognised so the recovered
  // RED phase gets its full dwell.
  light_dwell_timer #(
    .W (CW)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (illegal),
    .limit      (limit),
    .phase_done (phase_done)
  );

  // State and lamp registers. The lamp word is registered from the next
  // state so it changes on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RED;
      light <= LAMP_RED;
    end else begin
      state <= state_next;
      light <= light_next;
    end
  end

  // Next-state logic and per-phase terminal count.
  always_comb begin
    state_next = state;
    limit      = '0;
    illegal    = 1'b0;
    case (state)
      S_RED: begin
        limit = RED_LIM;
        if (phase_done) state_next = S_GREEN;
      end
      S_GREEN: begin
        limit = GREEN_LIM;
        if (phase_done) state_next = S_YELLOW;
      end
      S_YELLOW: begin
        limit = YELLOW_LIM;
        if (phase_done) state_next = S_RED;
      end
      default: begin
        illegal    = 1'b1;
        state_next = S_RED;
      end
    endcase
  end

  // Moore output decode.
  always_comb begin
    light_next = lamp_of(state_next);
  end

endmodule

// File: tb/tb_light_controller.sv
module tb_light_controller;
  import light_controller_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [0:2] l0;
  logic [0:2] l1;

  int n_chk  = 0;
  int n_fail = 0;

  // dut0 uses the default dwell of 1/1/1; dut1 uses 3/2/1.
  light_controller dut0 (
    .light (l0),
    .clk   (clk),
    .rst_n (rst_n)
  );

  light_controller #(
    .RED_CYCLES    (3),
    .GREEN_CYCLES  (2),
    .YELLOW_CYCLES (1)
  ) dut1 (
    .light (l1),
    .clk   (clk),
    .rst_n (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state and scoreboard queues.
  int         ph   [2];
  int         cnt  [2];
  bit         bad  [2];
  int         dur  [2][3] = '{'{1, 1, 1}, '{3, 2, 1}};
  logic [0:2] prev [2];
  logic [0:2] q0[$];
  logic [0:2] q1[$];

  logic [0:2] t0 [3] = '{3'b010, 3'b001, 3'b100};
  logic [0:2] t1 [6] = '{3'b100, 3'b100, 3'b010, 3'b010, 3'b001, 3'b100};

  function automatic logic [0:2] lamp(input int p);
    case (p)
      0:       return 3'b100;
      1:       return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  function automatic bit legal(input logic [0:2] a, input logic [0:2] b);
    return (a == 3'b100 && b == 3'b010) ||
           (a == 3'b010 && b == 3'b001) ||
           (a == 3'b001 && b == 3'b100);
  endfunction

  task automatic chk(input string tag, input logic [0:2] obs, input logic [0:2] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic [0:2] obs, input bit ok);
    n_chk++;
    assert (ok === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: observed light %b (prev %b/%b) expected legal one-hot", tag, obs, prev[0], prev[1]);
    end
  endtask

  // One clock edge: advance the model, queue expectations, sample #1 after the edge.
  task automatic step();
    bit         no_trans [2];
    logic [0:2] obs [2];
    logic [0:2] exp [2];
    for (int d = 0; d < 2; d++) begin
      no_trans[d] = !rst_n || bad[d];
      if (!rst_n || bad[d]) begin
        ph[d]  = 0;
        cnt[d] = 0;
        bad[d] = 1'b0;
      end else if (cnt[d] == dur[d][ph[d]] - 1) begin
        ph[d]  = (ph[d] + 1) % 3;
        cnt[d] = 0;
      end else begin
        cnt[d] = cnt[d] + 1;
      end
    end
    q0.push_back(lamp(ph[0]));
    q1.push_back(lamp(ph[1]));
    @(posedge clk);
    #1;
    obs[0] = l0;
    obs[1] = l1;
    exp[0] = q0.pop_front();
    exp[1] = q1.pop_front();
    chk("sb_dut0", obs[0], exp[0]);
    chk("sb_dut1", obs[1], exp[1]);
    for (int d = 0; d < 2; d++) begin
      chk_bit("onehot", obs[d], $countones(obs[d]) == 1);
      if (!no_trans[d] && obs[d] !== prev[d])
        chk_bit("transition", obs[d], legal(prev[d], obs[d]));
      prev[d] = obs[d];
    end
  endtask

  // Drop reset between edges and confirm the lamps go Red without a clock edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_dut0", l0, LAMP_RED);
    chk("async_rst_dut1", l1, LAMP_RED);
    prev[0] = l0;
    prev[1] = l1;
  endtask

  task automatic inject_illegal();
    force dut0.state = state_t'(2'b11);
    force dut1.state = state_t'(2'b11);
    #1;
    release dut0.state;
    release dut1.state;
    bad[0] = 1'b1;
    bad[1] = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      ph[d]   = 0;
      cnt[d]  = 0;
      bad[d]  = 1'b0;
      prev[d] = 3'b100;
    end

    // Reset held through the first edge.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_dut0", l0, LAMP_RED);
    chk("reset_dut1", l1, LAMP_RED);
    #6;
    rst_n = 1'b1;

    // Default and 3/2/1 sequences over three long periods.
    for (int i = 0; i < 18; i++) begin
      step();
      chk("seq_dflt", l0, t0[i % 3]);
      chk("seq_321", l1, t1[i % 6]);
    end

    // Reset in the middle of GREEN on the 3/2/1 instance.
    for (int i = 0; i < 3; i++) step();
    chk("mid_green", l1, LAMP_GREEN);
    async_reset();
    step();
    chk("held_rst_dut1", l1, LAMP_RED);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_dflt", l0, t0[i % 3]);
      chk("post_rst_321", l1, t1[i % 6]);
    end

    // Illegal state recovery.
    inject_illegal();
    step();
    chk("recover_dut0", l0, LAMP_RED);
    chk("recover_dut1", l1, LAMP_RED);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_fix_dflt", l0, t0[i % 3]);
      chk("post_fix_321", l1, t1[i % 6]);
    end

    // Random run lengths with random reset pulses and occasional upsets.
    for (int r = 0; r < 1000; r++) begin
      repeat ($urandom_range(1, 12)) step();
      if ($urandom_range(0, 3) == 0) begin
        async_reset();
        repeat ($urandom_range(1, 2)) step();
        rst_n = 1'b1;
      end else if ($urandom_range(0, 15) == 0) begin
        inject_illegal();
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
